// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Merges the pipeline writeback stream with results from a multicycle unit.
// Multicycle results are buffered in a 2-entry FIFO. A nonzero pipeline
// writeback always has priority. A busy scoreboard tracks multicycle
// destinations that have not been written back yet. A starvation counter
// requests a pipeline bubble when the FIFO head keeps losing arbitration.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_reg,
    input  logic [31:0] mc_data,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_reg,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        stall_req,
    output logic        issue_err,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // FIFO storage and pointers
    logic [4:0]  fifoRegMem  [2];
    logic [31:0] fifoDataMem [2];
    logic        rdPtrReg, wrPtrReg;
    logic [1:0]  countReg, countNext;

    // Scoreboard: bit 0 is implicit and always reads as 0
    logic [31:1] busyReg, busyNext;
    logic [31:0] busyFull;

    logic [CW-1:0] starveReg, starveNext;
    logic          issueErrReg;

    logic        wbReq, fifoNonEmpty, headSel, push, selWe;
    logic [4:0]  headReg, selAddr;
    logic [31:0] headData, selData;
    logic        issueClr, issueHit;

    // Arbitration and handshake decode
    always_comb begin
        fifoNonEmpty = (countReg != 2'd0);
        headReg      = fifoRegMem[rdPtrReg];
        headData     = fifoDataMem[rdPtrReg];
        wbReq        = wb_valid && (wb_reg != 5'd0);
        headSel      = !wbReq && fifoNonEmpty;
        push         = mc_valid && mc_ready;
        selWe        = wbReq || (headSel && (headReg != 5'd0));
        selAddr      = wbReq ? wb_reg  : headReg;
        selData      = wbReq ? wb_data : headData;
        countNext    = countReg + {1'b0, push} - {1'b0, headSel};
    end

    assign mc_ready = (countReg < 2'd2) && !rst;

    // Starvation counter: the counter climbs while the head loses to a
    // writeback. It saturates at the limit and clears on commit or when empty.
    always_comb begin
        starveNext = starveReg;
        if (!fifoNonEmpty || headSel)
            starveNext = '0;
        else if (starveReg != LIMIT)
            starveNext = starveReg + 1'b1;
    end

    assign stall_req = (starveReg == LIMIT) && fifoNonEmpty;

    // Per-register scoreboard next state; an issue overrides a same-cycle clear
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            logic setBit, clrBit;
            assign setBit = mc_issue && (mc_issue_reg == 5'(gi));
            assign clrBit = headSel && (headReg == 5'(gi));
            assign busyNext[gi] = setBit ? 1'b1 : (clrBit ? 1'b0 : busyReg[gi]);
        end
    endgenerate

    assign busyFull = {busyReg, 1'b0};
    assign rs_busy  = busyFull[rs_addr];
    assign rt_busy  = busyFull[rt_addr];

    // Issuing to a register that is still busy is an error, unless that register clears this cycle
    always_comb begin
        issueClr = headSel && (headReg == mc_issue_reg);
        issueHit = mc_issue && (mc_issue_reg != 5'd0) &&
                   busyFull[mc_issue_reg] && !issueClr;
    end

    assign issue_err = issueErrReg;

    // FIFO payload write; the contents are don't-care once count returns to 0
    always_ff @(posedge clk) begin
        if (push) begin
            fifoRegMem[wrPtrReg]  <= mc_reg;
            fifoDataMem[wrPtrReg] <= mc_data;
        end
    end

    // Control state: FIFO pointers and count, scoreboard, counter, error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtrReg    <= 1'b0;
            wrPtrReg    <= 1'b0;
            countReg    <= 2'd0;
            busyReg     <= '0;
            starveReg   <= '0;
            issueErrReg <= 1'b0;
        end else begin
            if (push)
                wrPtrReg <= ~wrPtrReg;
            if (headSel)
                rdPtrReg <= ~rdPtrReg;
            countReg  <= countNext;
            busyReg   <= busyNext;
            starveReg <= starveNext;
            if (issueHit)
                issueErrReg <= 1'b1;
        end
    end

    // Registered write port: address and data keep their last value when there is no write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= selWe;
            if (selWe) begin
                rf_waddr <= selAddr;
                rf_wdata <= selData;
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost-arbitration cycles before a pipeline bubble is requested.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wb_valid  input  1  pipeline writeback request; cannot be back-pressured.
REQ-005 wb_reg  input  5  pipeline destination register.
REQ-006 wb_data  input  32  pipeline writeback data.
REQ-007 mc_valid  input  1  multicycle-unit result valid.
REQ-008 mc_ready  output  1  block can accept a multicycle result.
REQ-009 mc_reg  input  5  multicycle destination register.
REQ-010 mc_data  input  32  multicycle result data.
REQ-011 mc_issue  input  1  multicycle operation issued this cycle.
REQ-012 mc_issue_reg  input  5  destination of the issued operation.
REQ-013 rs_addr, rt_addr  input  5 each  decode-stage source registers.
REQ-014 rs_busy, rt_busy  output  1 each  source has a pending multicycle write.
REQ-015 stall_req  output  1  request one writeback bubble from the pipeline.
REQ-016 issue_err  output  1  sticky: issue to an already-busy register.
REQ-017 rf_we, rf_waddr, rf_wdata  output  1/5/32  registered register-file write port.

Function
REQ-018 Multicycle results SHALL enter a 2-entry FIFO; mc_ready = (count < 2) and not rst; no same-cycle bypass to rf_*.
REQ-019 A handshake (mc_valid & mc_ready) SHALL push {mc_reg, mc_data}; mc_valid without mc_ready SHALL hold and be retried by the sender.
REQ-020 Each cycle the block SHALL select: wb_valid with wb_reg != 0 first; else the FIFO head; else nothing.
REQ-021 The selected write SHALL appear on rf_we/rf_waddr/rf_wdata on the next posedge (latency 1) and be held for exactly one cycle; with no selection, rf_we = 0 and addr/data retain last value.
REQ-022 A FIFO head committed SHALL be popped the same cycle it is selected; push and pop in one cycle SHALL leave count unchanged.
REQ-023 Writes to register 0 SHALL never assert rf_we; a FIFO entry with reg 0 SHALL be popped when selected without a write; wb to reg 0 SHALL count as no wb request.
REQ-024 Scoreboard: 32-bit busy vector; mc_issue with mc_issue_reg != 0 SHALL set its bit at the next posedge.
REQ-025 A busy bit SHALL clear on the cycle its FIFO entry is selected for commit; if issue and clear target the same register in one cycle, set SHALL win.
REQ-026 mc_issue to a register already busy (and not clearing that cycle) SHALL set issue_err, held until reset.
REQ-027 rs_busy = busy[rs_addr], rt_busy = busy[rt_addr], combinational; bit 0 SHALL always read 0.
REQ-028 wb writes SHALL not modify the scoreboard.
REQ-029 Starvation counter SHALL increment each cycle the FIFO is non-empty and loses to wb, reset to 0 when the head commits or the FIFO is empty, and saturate at STARVE_LIMIT.
REQ-030 stall_req SHALL be 1 while counter == STARVE_LIMIT and the FIFO is non-empty; a wb arriving during stall_req SHALL still win and the counter SHALL hold.

Reset
REQ-031 rst SHALL immediately clear FIFO (count 0), busy vector, counter, issue_err, rf_we, rf_waddr = 0, rf_wdata = 0, stall_req = 0, mc_ready = 0.
REQ-032 Reset mid-operation SHALL discard buffered results without any rf write; mc_ready SHALL return to 1 on the first cycle after rst deasserts.

Verification
REQ-033 Idle FIFO, wb_valid reg 5 data 0xAAAA0001 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAAAA0001, one cycle only.
REQ-034 mc_issue reg 7; later mc push reg 7 data 0x12345678 with wb idle -> rs_busy=1 for rs_addr=7 until commit, rf write of reg 7 two cycles after push, busy cleared.
REQ-035 Two mc pushes back-to-back while wb_valid continuous -> mc_ready=0 after second push, stall_req=1 after 4 lost cycles; wb drops for one cycle -> head commits, counter 0, mc_ready=1.
REQ-036 Simultaneous wb (reg 3) and FIFO head (reg 4) -> reg 3 written first, reg 4 next cycle when wb idle.
REQ-037 mc_issue reg 9 twice without commit -> issue_err=1 sticky; mc push with reg 0 -> popped, no rf_we.
REQ-038 Assert rst with 2 entries buffered and busy bits set -> all outputs zero immediately, no rf write, busy all 0 after release.
